seg7_scan_reader: RTL and testbench
===================================

Name: seg7_scan_reader

Overview:
- Receive-side counterpart of the 4-digit hex display path: accepts a time-multiplexed 7-segment drive (shared segment bus, one-hot digit select, decimal point).
- Decodes each stable digit pattern back to a nibble and reassembles the 16-bit counter word plus the overflow dot.
- Presents a validated word with a one-cycle strobe.
- Used on the board-readback/test harness to check the Fibonacci tile chain output without probing internal sums.

Parameters:
- SETTLE, 2, consecutive unchanged cycles (sel, seg, dp) required before a digit is sampled; legal range 1..15.
- SEG_ACTIVE_LOW, 1, 1 = segment/dp inputs are active-low and are inverted before decode; 0 = active-high.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- seg  in  7  segment bus; bit0=a, bit1=b … bit6=g.
- dp  in  1  decimal point of the currently selected digit.
- dig_sel  in  4  one-hot digit select, active-high; bit0 = least-significant nibble (word[3:0]), bit3 = word[15:12].
- word  out  16  last completed frame value.
- ovf  out  1  dp level captured from digit 0 in the last completed frame.
- word_valid  out  1  one-cycle pulse: word/ovf/frame_err updated this cycle.
- frame_err  out  1  qualifies word_valid; 1 if any digit in that frame had an undecodable pattern.
- changed  out  1  one-cycle pulse with word_valid when {ovf,word} differs from the previous completed frame.

Behaviour:
- Reset (reset=0, asynchronous): word=0, ovf=0, word_valid=0, frame_err=0, changed=0, state=IDLE, stable_cnt=0, capture mask=0, staging=0, err_mask=0, prev regs=0.
- Input normalisation: when SEG_ACTIVE_LOW=1, seg and dp are inverted first; all decode uses active-high patterns.
- Decode table (active-high hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other pattern is invalid: nibble stored as 0 and the digit's err bit is set.
- Stability counter: prev_{sel,seg,dp} are registered every cycle.
  - Any difference from current inputs → stable_cnt=0.
  - Otherwise stable_cnt increments, saturating at SETTLE.
- FSM states:
  - IDLE: dig_sel not one-hot (0 or multi-hot). Clears capture mask and err_mask (frame broken). Leaves IDLE when dig_sel becomes one-hot, going to SETTLE.
  - SETTLE: counting. When stable_cnt reaches SETTLE, capture the digit: write the nibble into staging[4*i+3:4*i], set mask[i], set or clear err_mask[i], latch dp if i=0. Then go to HOLD.
  - HOLD: digit held. A seg/dp change with the same sel returns to SETTLE and recaptures, overwriting the digit. A sel change to another one-hot value goes to SETTLE. A non-one-hot sel goes to IDLE.
- Capture latency: with inputs constant from cycle t, the capture occurs in cycle t+SETTLE (registered state updated at that edge).
- Frame completion: in the cycle after the capture that makes mask=4'hF:
  - word←staging, ovf←dp latch, frame_err←|err_mask.
  - word_valid=1; changed=1 if the new {ovf,word} ≠ old.
  - mask and err_mask clear; staging is retained.
- Recapturing the same digit within a frame overwrites it with no error. Order of digits is irrelevant.
- word, ovf and frame_err hold between strobes. word_valid and changed are single-cycle.
- Mid-operation reset clears everything immediately; the first strobe after release requires four fresh captures.

Test Plan:
- Reset: assert reset=0 during an active scan → all outputs 0 asynchronously; no word_valid until four new captures after release.
- Normal scan (SEG_ACTIVE_LOW=1, SETTLE=2): drive digits 0..3 with ~{06}, ~{79}, ~{77}, ~{71}, each held 4 cycles, dp inactive → exactly one word_valid with word=16'hFAE1, ovf=0, frame_err=0, changed=1. Repeating the same scan → word_valid=1, changed=0.
- Settle filter: seg toggles every cycle while dig_sel=4'b0001 → no capture. Hold it stable for exactly SETTLE cycles → capture on that cycle, not earlier.
- Invalid pattern: digit 2 shows 7'h00 (active-high) in an otherwise valid 0x1234 scan → word=16'h1034, frame_err=1 with word_valid.
- Broken frame: capture digits 0,1, then dig_sel=4'b0011 for 1 cycle, then digits 2,3 → no strobe. A complete 4-digit scan afterwards → strobe.
- Overflow dot: dp active on digit 0, word 0x0000 → ovf=1, changed=1. dp moved to digit 1 only → next frame ovf=0.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Reads back a time-multiplexed 4-digit 7-segment drive and rebuilds the
// 16-bit word plus digit-0 dot, strobing once per completed 4-digit frame.
module seg7_scan_reader #(
    parameter int SETTLE         = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic        dp,
    input  logic [3:0]  dig_sel,
    output logic [15:0] word,
    output logic        ovf,
    output logic        word_valid,
    output logic        frame_err,
    output logic        changed
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE);
    localparam logic [3:0] CAP_CNT    = 4'(SETTLE - 1);

    logic [6:0]  seg_h;
    logic        dp_h;
    logic [3:0]  prev_sel;
    logic [6:0]  prev_seg;
    logic        prev_dp;
    logic [3:0]  stable_cnt;
    logic [1:0]  state, state_nxt;
    logic [3:0]  mask, mask_nxt;
    logic [3:0]  err_mask, err_nxt;
    logic [15:0] staging;
    logic        dp_lat;
    logic        same, one_hot, capture, complete;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic        nib_ok;

    assign seg_h = SEG_ACTIVE_LOW ? ~seg : seg;
    assign dp_h  = SEG_ACTIVE_LOW ? ~dp  : dp;

    assign same     = (dig_sel == prev_sel) && (seg_h == prev_seg) && (dp_h == prev_dp);
    assign one_hot  = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
    // Counter hits SETTLE on this edge, so the sample lands SETTLE cycles after the change.
    assign capture  = (state == S_SETTLE) && one_hot && same && (stable_cnt >= CAP_CNT);
    assign complete = (mask == 4'hF);

    always_comb begin
        idx = 2'd0;
        case (dig_sel)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b1;
        case (seg_h)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: nib_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (one_hot) state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (!one_hot)     state_nxt = S_IDLE;
                else if (capture) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!one_hot)   state_nxt = S_IDLE;
                else if (!same) state_nxt = S_SETTLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A non-one-hot select breaks the frame; completion and capture never coincide.
    always_comb begin
        mask_nxt = mask;
        err_nxt  = err_mask;
        if (!one_hot) begin
            mask_nxt = 4'd0;
            err_nxt  = 4'd0;
        end else begin
            if (complete) begin
                mask_nxt = 4'd0;
                err_nxt  = 4'd0;
            end
            if (capture) begin
                mask_nxt[idx] = 1'b1;
                err_nxt[idx]  = ~nib_ok;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_sel   <= 4'd0;
            prev_seg   <= 7'd0;
            prev_dp    <= 1'b0;
            stable_cnt <= 4'd0;
            state      <= S_IDLE;
            mask       <= 4'd0;
            err_mask   <= 4'd0;
            staging    <= 16'd0;
            dp_lat     <= 1'b0;
            word       <= 16'd0;
            ovf        <= 1'b0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            changed    <= 1'b0;
        end else begin
            prev_sel <= dig_sel;
            prev_seg <= seg_h;
            prev_dp  <= dp_h;
            if (!same)
                stable_cnt <= 4'd0;
            else if (stable_cnt < SETTLE_MAX)
                stable_cnt <= stable_cnt + 4'd1;
            state    <= state_nxt;
            mask     <= mask_nxt;
            err_mask <= err_nxt;
            if (capture) begin
                staging[4*idx +: 4] <= nib_ok ? nib : 4'h0;
                if (idx == 2'd0)
                    dp_lat <= dp_h;
            end
            word_valid <= 1'b0;
            changed    <= 1'b0;
            if (complete) begin
                word       <= staging;
                ovf        <= dp_lat;
                frame_err  <= |err_mask;
                word_valid <= 1'b1;
                changed    <= ({dp_lat, staging} != {ovf, word});
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (SETTLE=2, active-low segments):
// table of full-frame scans plus hand sequences for settle, broken frame, reset.
module tb_seg7_scan_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig_sel;
    logic [15:0] word;
    logic        ovf, word_valid, frame_err, changed;

    int tests = 0;
    int fails = 0;
    int nstrobe = 0;
    logic last_chg = 1'b0;

    seg7_scan_reader #(.SETTLE(2), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .seg(seg), .dp(dp), .dig_sel(dig_sel),
        .word(word), .ovf(ovf), .word_valid(word_valid),
        .frame_err(frame_err), .changed(changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid) begin
            nstrobe  <= nstrobe + 1;
            last_chg <= changed;
        end
    end

    typedef struct {
        logic [15:0] w;
        logic [3:0]  dps;
        logic [3:0]  bad;
        logic [15:0] e_word;
        logic        e_ovf;
        logic        e_err;
        logic        e_chg;
    } vec_t;

    vec_t vec [7];

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'h3F; 4'h1: enc = 7'h06; 4'h2: enc = 7'h5B; 4'h3: enc = 7'h4F;
            4'h4: enc = 7'h66; 4'h5: enc = 7'h6D; 4'h6: enc = 7'h7D; 4'h7: enc = 7'h07;
            4'h8: enc = 7'h7F; 4'h9: enc = 7'h6F; 4'hA: enc = 7'h77; 4'hB: enc = 7'h7C;
            4'hC: enc = 7'h39; 4'hD: enc = 7'h5E; 4'hE: enc = 7'h79; default: enc = 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dig_sel = 4'd0;
        seg     = 7'h7F;
        dp      = 1'b1;
        tick(n);
    endtask

    // pat and d are active-high; driven inverted onto the active-low bus
    task automatic show(input int i, input logic [6:0] pat, input logic d, input int n);
        dig_sel = 4'(1 << i);
        seg     = ~pat;
        dp      = ~d;
        tick(n);
    endtask

    task automatic scan(input logic [15:0] w, input logic [3:0] dps, input logic [3:0] bad);
        logic [6:0] pat;
        for (int d = 0; d < 4; d++) begin
            pat = bad[d] ? 7'h00 : enc(w[4*d +: 4]);
            show(d, pat, dps[d], 4);
        end
    endtask

    initial begin
        int base;
        vec[0] = '{16'hFAE1, 4'h0, 4'h0, 16'hFAE1, 1'b0, 1'b0, 1'b1};
        vec[1] = '{16'hFAE1, 4'h0, 4'h0, 16'hFAE1, 1'b0, 1'b0, 1'b0};
        vec[2] = '{16'h1234, 4'h0, 4'h4, 16'h1034, 1'b0, 1'b1, 1'b1};
        vec[3] = '{16'h0000, 4'h1, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vec[4] = '{16'h0000, 4'h2, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vec[5] = '{16'h0000, 4'h0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vec[6] = '{16'h89BC, 4'h9, 4'h0, 16'h89BC, 1'b1, 1'b0, 1'b1};

        reset = 1'b0;
        dig_sel = 4'd0;
        seg = 7'h7F;
        dp = 1'b1;
        tick(3);
        chk("rst_word", 32'(word), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_valid", 32'(word_valid), 32'h0);
        chk("rst_err", 32'(frame_err), 32'h0);
        chk("rst_changed", 32'(changed), 32'h0);
        reset = 1'b1;
        tick(2);

        for (int v = 0; v < 7; v++) begin
            idle(2);
            base = nstrobe;
            scan(vec[v].w, vec[v].dps, vec[v].bad);
            idle(3);
            chk($sformatf("v%0d_strobes", v), 32'(nstrobe - base), 32'd1);
            chk($sformatf("v%0d_word", v), 32'(word), 32'(vec[v].e_word));
            chk($sformatf("v%0d_ovf", v), 32'(ovf), 32'(vec[v].e_ovf));
            chk($sformatf("v%0d_err", v), 32'(frame_err), 32'(vec[v].e_err));
            chk($sformatf("v%0d_changed", v), 32'(last_chg), 32'(vec[v].e_chg));
        end

        // settle filter: digits 1..3 captured, digit 0 only sampled after SETTLE unchanged cycles
        idle(2);
        base = nstrobe;
        show(1, enc(4'h3), 1'b0, 4);
        show(2, enc(4'h2), 1'b0, 4);
        show(3, enc(4'h1), 1'b0, 4);
        for (int k = 0; k < 6; k++) show(0, enc(4'(5 + (k % 2))), 1'b0, 1);
        show(0, enc(4'h7), 1'b0, 2);
        for (int k = 0; k < 6; k++) show(0, enc(4'(5 + (k % 2))), 1'b0, 1);
        chk("settle_early", 32'(nstrobe - base), 32'd0);
        show(0, enc(4'h7), 1'b0, 3);
        for (int k = 0; k < 6; k++) show(0, enc(4'(5 + (k % 2))), 1'b0, 1);
        chk("settle_strobe", 32'(nstrobe - base), 32'd1);
        chk("settle_word", 32'(word), 32'h1237);

        // broken frame: multi-hot select between halves discards digits 0,1
        idle(2);
        base = nstrobe;
        show(0, enc(4'hA), 1'b0, 4);
        show(1, enc(4'h5), 1'b0, 4);
        dig_sel = 4'b0011;
        tick(1);
        show(2, enc(4'hA), 1'b0, 4);
        show(3, enc(4'h5), 1'b0, 4);
        idle(3);
        chk("broken_nostrobe", 32'(nstrobe - base), 32'd0);
        scan(16'h5A5A, 4'h0, 4'h0);
        idle(3);
        chk("broken_strobe", 32'(nstrobe - base), 32'd1);
        chk("broken_word", 32'(word), 32'h5A5A);

        // mid-scan async reset
        scan(16'h4321, 4'h1, 4'h0);
        idle(3);
        chk("pre_rst_word", 32'(word), 32'h4321);
        show(0, enc(4'h1), 1'b0, 4);
        show(1, enc(4'h2), 1'b0, 4);
        #3 reset = 1'b0;
        #1;
        chk("async_word", 32'(word), 32'h0);
        chk("async_ovf", 32'(ovf), 32'h0);
        chk("async_err", 32'(frame_err), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        base = nstrobe;
        show(2, enc(4'h3), 1'b0, 4);
        show(3, enc(4'h4), 1'b0, 4);
        idle(3);
        chk("post_rst_nostrobe", 32'(nstrobe - base), 32'd0);
        scan(16'h4321, 4'h0, 4'h0);
        idle(3);
        chk("post_rst_strobe", 32'(nstrobe - base), 32'd1);
        chk("post_rst_word", 32'(word), 32'h4321);
        chk("post_rst_changed", 32'(last_chg), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
